dcache_wb_ctrl: RTL

- Direct-mapped, write-back, write-allocate data cache for the MEM stage.
- Replaces the single-line cache model between the EX/MEM register and main memory.
- Hits complete combinationally in the same cycle. Misses assert Stall, which freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB, while an FSM writes back the dirty victim line and refills one word at a time over a req/ack memory port.

---
 rtl/dcache_wb_ctrl_if.sv | 20 ++
 rtl/dcache_wb_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb_ctrl_if.sv
// Word-wide req/ack memory port between the data cache and main memory.
// The cache drives the request side (master); the memory answers (slave).
interface dcache_wb_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dcache_wb_ctrl.sv
// Direct-mapped write-back/write-allocate MEM-stage data cache with word-serial miss handling.
// Define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module dcache_wb_ctrl #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MByte,
    output logic [31:0] ReadData,
    output logic        Stall,
    dcache_wb_ctrl_if.master mem
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int IW = $clog2(LINES);
    localparam int OW = $clog2(WORDS);
    localparam int TW = 30 - OW - IW;
    localparam logic [OW-1:0] LASTK = OW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

    state_t        state;
    logic [OW-1:0] k;
    logic [OW-1:0] kNext;
    logic [LINES-1:0] valid;
    logic [LINES-1:0] dirty;
    logic [TW-1:0] tagArr  [0:LINES-1];
    logic [31:0]   dataArr [0:LINES*WORDS-1];
    logic [31:0]   rdHold;

    logic [TW-1:0] tag;
    logic [IW-1:0] idx;
    logic [OW-1:0] wsel;
    logic          active;
    logic          hit;
    logic          serve;
    logic [31:0]   curWord;
    logic [4:0]    sh;
    logic [31:0]   shifted;
    logic [31:0]   loadVal;
    logic [3:0]    be;
    logic [31:0]   wdAligned;

    assign tag     = Address[31 -: TW];
    assign idx     = Address[2+OW +: IW];
    assign wsel    = Address[2 +: OW];
    assign active  = MemRead | MemWrite;
    assign hit     = valid[idx] && (tagArr[idx] == tag);
    // DONE re-presents the access as a hit on the freshly filled line.
    assign serve   = ((state == IDLE) || (state == DONE)) && active && hit;
    assign curWord = dataArr[{idx, wsel}];
    assign kNext   = k + OW'(1);

    always_comb begin
        sh        = '0;
        loadVal   = curWord;
        be        = '1;
        wdAligned = WriteData;
        case (MByte)
            2'b01: begin
                sh        = {Address[1], 4'b0000};
                be        = Address[1] ? 4'b1100 : 4'b0011;
                wdAligned = {2{WriteData[15:0]}};
            end
            2'b10: begin
                sh        = {Address[1:0], 3'b000};
                be        = 4'b0001 << Address[1:0];
                wdAligned = {4{WriteData[7:0]}};
            end
            default: ;
        endcase
        shifted = curWord >> sh;
        case (MByte)
            2'b01:   loadVal = {16'h0000, shifted[15:0]};
            2'b10:   loadVal = {24'h000000, shifted[7:0]};
            default: loadVal = curWord;
        endcase
    end

    assign ReadData = (serve && !MemWrite) ? loadVal : rdHold;
    assign Stall    = !reset && (((state == IDLE) && active && !hit) ||
                                 (state == WB) || (state == FILL));

    // Line storage carries no reset; valid bits alone decide whether contents count.
    always_ff @(posedge Clk) begin
        if (state == FILL && mem.mem_ack) begin
            dataArr[{idx, k}] <= mem.mem_rdata;
            if (k == LASTK) tagArr[idx] <= tag;
        end else if (serve && MemWrite) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) dataArr[{idx, wsel}][8*b +: 8] <= wdAligned[8*b +: 8];
            end
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            k             <= '0;
            valid         <= '0;
            dirty         <= '0;
            rdHold        <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            if (serve && !MemWrite) rdHold <= loadVal;
            if (serve && MemWrite) dirty[idx] <= 1'b1;
            case (state)
                IDLE: begin
                    if (active && !hit) begin
                        k           <= '0;
                        mem.mem_req <= 1'b1;
                        if (valid[idx] && dirty[idx]) begin
                            state         <= WB;
                            mem.mem_we    <= 1'b1;
                            mem.mem_addr  <= {tagArr[idx], idx, {OW{1'b0}}, 2'b00};
                            mem.mem_wdata <= dataArr[{idx, {OW{1'b0}}}];
                        end else begin
                            state        <= FILL;
                            mem.mem_we   <= 1'b0;
                            mem.mem_addr <= {tag, idx, {OW{1'b0}}, 2'b00};
                        end
                    end
                end
                WB: begin
                    if (mem.mem_ack) begin
                        if (k == LASTK) begin
                            dirty[idx]   <= 1'b0;
                            state        <= FILL;
                            k            <= '0;
                            mem.mem_we   <= 1'b0;
                            mem.mem_addr <= {tag, idx, {OW{1'b0}}, 2'b00};
                        end else begin
                            k             <= kNext;
                            mem.mem_addr  <= {tagArr[idx], idx, kNext, 2'b00};
                            mem.mem_wdata <= dataArr[{idx, kNext}];
                        end
                    end
                end
                FILL: begin
                    if (mem.mem_ack) begin
                        if (k == LASTK) begin
                            valid[idx]  <= 1'b1;
                            dirty[idx]  <= 1'b0;
                            state       <= DONE;
                            k           <= '0;
                            mem.mem_req <= 1'b0;
                        end else begin
                            k            <= kNext;
                            mem.mem_addr <= {tag, idx, kNext, 2'b00};
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && active) begin
            if (hit) begin
                if (hit_count != '1) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != '1) miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
